// File: rtl/itch_msg_sequencer.sv
// ITCH message front-end: parses a length-prefixed byte stream and drives the shared decoder bus.
// Optional saturating statistics counters are enabled with the ITCH_SEQ_STATS_EN macro.
module itch_msg_sequencer #(
  parameter int MAX_LEN = 63,
  parameter int MIN_LEN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic [7:0]  payload_out,
  output logic        payload_valid_out,
  output logic        start_flag,
  output logic [5:0]  expected_length,
  output logic        length_valid,
  output logic [3:0]  dec_sel,
  output logic [7:0]  msg_type,
  output logic        msg_done,
  output logic        len_err,
  output logic        drop_err
`ifdef ITCH_SEQ_STATS_EN
  ,
  output logic [31:0] stat_msgs,
  output logic [15:0] stat_drops,
  output logic [15:0] stat_len_errs
`endif
);

  localparam logic [15:0] LP_MIN = 16'(MIN_LEN);
  localparam logic [15:0] LP_MAX = 16'(MAX_LEN);

  typedef enum logic [1:0] {S_LEN_HI, S_LEN_LO, S_BODY, S_DROP} state_t;

  state_t      r_state;
  logic [7:0]  r_len_hi;
  logic [15:0] r_rem;
  logic        r_first;
  logic [7:0]  r_payload;
  logic        r_pv;
  logic        r_start;
  logic [5:0]  r_exp_len;
  logic        r_lv;
  logic [3:0]  r_dec_sel;
  logic [7:0]  r_msg_type;
  logic        r_done;
  logic        r_len_err;
  logic        r_drop_err;

  logic [15:0] w_len;
  logic        w_len_bad;
  logic [3:0]  w_sel;
  logic [15:0] w_tbl_len;
  logic        w_known;

  assign w_len     = {r_len_hi, in_byte};
  assign w_len_bad = (w_len < LP_MIN) || (w_len > LP_MAX);

  // Fixed body-length table for the four decoded message types.
  always_comb begin
    w_sel     = 4'b0000;
    w_tbl_len = 16'd0;
    case (in_byte)
      8'h41:   begin w_sel = 4'b0001; w_tbl_len = 16'd36; end
      8'h58:   begin w_sel = 4'b0010; w_tbl_len = 16'd23; end
      8'h44:   begin w_sel = 4'b0100; w_tbl_len = 16'd19; end
      8'h45:   begin w_sel = 4'b1000; w_tbl_len = 16'd31; end
      default: begin w_sel = 4'b0000; w_tbl_len = 16'd0;  end
    endcase
  end

  assign w_known = |w_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_LEN_HI;
      r_len_hi   <= 8'd0;
      r_rem      <= 16'd0;
      r_first    <= 1'b0;
      r_payload  <= 8'd0;
      r_pv       <= 1'b0;
      r_start    <= 1'b0;
      r_exp_len  <= 6'd0;
      r_lv       <= 1'b0;
      r_dec_sel  <= 4'd0;
      r_msg_type <= 8'd0;
      r_done     <= 1'b0;
      r_len_err  <= 1'b0;
      r_drop_err <= 1'b0;
    end else begin
      r_start    <= 1'b0;
      r_lv       <= r_start;  // decoders clear on start_flag, then relatch length
      r_pv       <= 1'b0;
      r_done     <= 1'b0;
      r_len_err  <= 1'b0;
      r_drop_err <= 1'b0;
      case (r_state)
        S_LEN_HI: begin
          if (in_valid) begin
            r_len_hi <= in_byte;
            r_state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (in_valid) begin
            r_rem <= w_len;
            if (w_len_bad) begin
              r_drop_err <= 1'b1;
              r_state    <= (w_len == 16'd0) ? S_LEN_HI : S_DROP;
            end else begin
              r_exp_len <= w_len[5:0];
              r_start   <= 1'b1;
              r_dec_sel <= 4'd0;
              r_first   <= 1'b1;
              r_state   <= S_BODY;
            end
          end
        end
        S_BODY: begin
          if (in_valid) begin
            r_payload <= in_byte;
            r_pv      <= 1'b1;
            r_first   <= 1'b0;
            if (r_first) begin
              r_msg_type <= in_byte;
              r_dec_sel  <= w_sel;
              r_len_err  <= w_known && (r_rem != w_tbl_len);
            end
            if (r_rem != 16'd0) r_rem <= r_rem - 16'd1;
            if (r_rem <= 16'd1) begin
              r_done  <= 1'b1;
              r_state <= S_LEN_HI;
            end
          end
        end
        S_DROP: begin
          if (in_valid) begin
            if (r_rem != 16'd0) r_rem <= r_rem - 16'd1;
            if (r_rem <= 16'd1) r_state <= S_LEN_HI;
          end
        end
        default: r_state <= S_LEN_HI;
      endcase
    end
  end

  assign payload_out       = r_payload;
  assign payload_valid_out = r_pv;
  assign start_flag        = r_start;
  assign expected_length   = r_exp_len;
  assign length_valid      = r_lv;
  assign dec_sel           = r_dec_sel;
  assign msg_type          = r_msg_type;
  assign msg_done          = r_done;
  assign len_err           = r_len_err;
  assign drop_err          = r_drop_err;

`ifdef ITCH_SEQ_STATS_EN
  logic [31:0] r_stat_msgs;
  logic [15:0] r_stat_drops;
  logic [15:0] r_stat_len_errs;

  // Counters follow the registered event pulses, so they land one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_msgs     <= 32'd0;
      r_stat_drops    <= 16'd0;
      r_stat_len_errs <= 16'd0;
    end else begin
      if (r_done && (r_stat_msgs != '1))         r_stat_msgs     <= r_stat_msgs + 32'd1;
      if (r_drop_err && (r_stat_drops != '1))    r_stat_drops    <= r_stat_drops + 16'd1;
      if (r_len_err && (r_stat_len_errs != '1))  r_stat_len_errs <= r_stat_len_errs + 16'd1;
    end
  end

  assign stat_msgs     = r_stat_msgs;
  assign stat_drops    = r_stat_drops;
  assign stat_len_errs = r_stat_len_errs;
`endif

endmodule

// File: tb/tb_itch_msg_sequencer.sv
// Bench for itch_msg_sequencer: table of messages plus a mid-message reset sequence.
module tb_itch_msg_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_byte;
  logic       in_valid;
  logic [7:0] payload_out;
  logic       payload_valid_out;
  logic       start_flag;
  logic [5:0] expected_length;
  logic       length_valid;
  logic [3:0] dec_sel;
  logic [7:0] msg_type;
  logic       msg_done;
  logic       len_err;
  logic       drop_err;
`ifdef ITCH_SEQ_STATS_EN
  logic [31:0] stat_msgs;
  logic [15:0] stat_drops;
  logic [15:0] stat_len_errs;
`endif

  itch_msg_sequencer dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid),
    .payload_out(payload_out), .payload_valid_out(payload_valid_out),
    .start_flag(start_flag), .expected_length(expected_length),
    .length_valid(length_valid), .dec_sel(dec_sel), .msg_type(msg_type),
    .msg_done(msg_done), .len_err(len_err), .drop_err(drop_err)
`ifdef ITCH_SEQ_STATS_EN
    , .stat_msgs(stat_msgs), .stat_drops(stat_drops), .stat_len_errs(stat_len_errs)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] len;
    logic [7:0]  typ;
    bit          gaps;
    logic [3:0]  sel;
    bit          lerr;
    bit          drop;
    bit          b2b;
  } vec_t;

  typedef struct {
    logic [7:0] b;
    bit         done;
    bit         lerr;
    logic [3:0] sel;
  } exp_t;

  exp_t       pq[$];
  logic [5:0] len_q[$];
  int total = 0, bad = 0;
  int n_done = 0, n_drop = 0, n_lerr = 0;
  int x_done = 0, x_drop = 0, x_lerr = 0;
  bit prev_start = 1'b0;
  bit have_good = 1'b0;
  logic [7:0] last_type = 8'd0;
  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Output monitor: pops expected payload records, checks pulse alignment.
  always @(negedge clk) begin
    if (payload_valid_out) begin
      if (pq.size() == 0) begin
        check("unexpected_payload", 32'(payload_out), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = pq.pop_front();
        check("payload", 32'(payload_out), 32'(e.b));
        check("msg_done", 32'(msg_done), 32'(e.done));
        check("len_err", 32'(len_err), 32'(e.lerr));
        check("dec_sel", 32'(dec_sel), 32'(e.sel));
      end
    end else begin
      check("done_idle", 32'(msg_done), 32'd0);
      check("lerr_idle", 32'(len_err), 32'd0);
    end
    check("length_valid", 32'(length_valid), 32'(prev_start));
    if (start_flag) begin
      check("start_vs_payload", 32'(payload_valid_out), 32'd0);
      if (len_q.size() == 0) check("unexpected_start", 32'd1, 32'd0);
      else check("expected_length", 32'(expected_length), 32'(len_q.pop_front()));
    end
    if (msg_done) n_done++;
    if (drop_err) n_drop++;
    if (len_err)  n_lerr++;
    prev_start = start_flag;
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      int n;
      n = int'($urandom_range(0, 2));
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_byte  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_msg(input vec_t v);
    logic [7:0] b;
    send_byte(v.len[15:8], v.gaps);
    if (!v.drop) len_q.push_back(v.len[5:0]);
    send_byte(v.len[7:0], v.gaps);
    for (int i = 0; i < int'(v.len); i++) begin
      b = (i == 0) ? v.typ : 8'($urandom);
      if (!v.drop) pq.push_back('{b, (i == int'(v.len) - 1), (i == 0) && v.lerr, v.sel});
      send_byte(b, v.gaps);
    end
    if (v.drop) x_drop++;
    else begin
      x_done++;
      have_good = 1'b1;
      last_type = v.typ;
    end
    if (v.lerr) x_lerr++;
  endtask

  task automatic drain_check(input string tag);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_done_cnt"}, 32'(n_done), 32'(x_done));
    check({tag, "_drop_cnt"}, 32'(n_drop), 32'(x_drop));
    check({tag, "_lerr_cnt"}, 32'(n_lerr), 32'(x_lerr));
    check({tag, "_pq_empty"}, 32'(pq.size()), 32'd0);
    check({tag, "_lenq_empty"}, 32'(len_q.size()), 32'd0);
    if (have_good) check({tag, "_msg_type"}, 32'(msg_type), 32'(last_type));
  endtask

  initial begin
    logic [7:0] b;
    //         len     typ    gaps sel     lerr drop b2b
    tbl[0]  = '{16'd36,  8'h41, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{16'd19,  8'h44, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{16'd20,  8'h44, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{16'd80,  8'h41, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{16'd23,  8'h58, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{16'd1,   8'h45, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{16'd0,   8'h00, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{16'd64,  8'h41, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{16'd63,  8'h5A, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{16'd31,  8'h45, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{16'd256, 8'h44, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{16'd36,  8'h58, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{16'd1,   8'h51, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_byte = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {payload_out, payload_valid_out, start_flag, expected_length,
                         length_valid, dec_sel, msg_type, msg_done, len_err, drop_err}, 32'd0);
`ifdef ITCH_SEQ_STATS_EN
    check("reset_stats", 32'(stat_msgs) | 32'(stat_drops) | 32'(stat_len_errs), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      send_msg(tbl[i]);
      if (!tbl[i].b2b) drain_check($sformatf("vec%0d", i));
    end

`ifdef ITCH_SEQ_STATS_EN
    check("stat_msgs", stat_msgs, 32'(x_done));
    check("stat_drops", 32'(stat_drops), 32'(x_drop));
    check("stat_len_errs", 32'(stat_len_errs), 32'(x_lerr));
`endif

    // Reset lands on body byte 10 of an 'A' message: nothing after byte 9 may appear.
    send_byte(8'h00, 1'b0);
    len_q.push_back(6'd36);
    send_byte(8'h24, 1'b0);
    for (int i = 0; i < 9; i++) begin
      b = (i == 0) ? 8'h41 : 8'($urandom);
      pq.push_back('{b, 1'b0, 1'b0, 4'b0001});
      send_byte(b, 1'b0);
    end
    in_valid = 1'b1; in_byte = 8'hAA; rst = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b0;
    check("midreset_outs", {payload_out, payload_valid_out, start_flag, expected_length,
                            length_valid, dec_sel, msg_type, msg_done, len_err, drop_err}, 32'd0);
`ifdef ITCH_SEQ_STATS_EN
    check("midreset_stats", 32'(stat_msgs) | 32'(stat_drops) | 32'(stat_len_errs), 32'd0);
`endif
    have_good = 1'b0;
    drain_check("after_rst");

    send_msg('{16'd31, 8'h45, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0});
    drain_check("post_rst_E");
`ifdef ITCH_SEQ_STATS_EN
    check("post_rst_stat_msgs", stat_msgs, 32'd1);
    check("post_rst_stat_drops", 32'(stat_drops), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/itch_msg_sequencer.md
Name: itch_msg_sequencer

Overview:
- Front-end controller for the speculative ITCH decoders (add order, cancel, delete, execute).
- Consumes a length-prefixed byte stream: 2-byte big-endian length, then message body.
- Drives the shared decoder byte bus (`payload_out`, `start_flag`, `expected_length`, `length_valid`) with the timing the decoders require.
- Decodes the type byte into a one-hot decoder select, flags malformed messages and pulses `msg_done` at end of body.

Parameters:
- MAX_LEN, 63: largest legal body length; must be ≤ 63 to fit the 6-bit `expected_length`.
- MIN_LEN, 1: smallest legal body length (the type byte only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_byte  in  8  stream byte
- in_valid  in  1  in_byte valid this cycle
- payload_out  out  8  byte to decoders, registered
- payload_valid_out  out  1  payload_out valid
- start_flag  out  1  one-cycle pulse, precedes first body byte
- expected_length  out  6  body length of current message
- length_valid  out  1  one-cycle pulse, expected_length valid
- dec_sel  out  4  one-hot select: [0]='A', [1]='X', [2]='D', [3]='E'; 0 for any other type
- msg_type  out  8  latched type byte
- msg_done  out  1  one-cycle pulse with the last body byte on payload_out
- len_err  out  1  one-cycle pulse: known type but length ≠ table value
- drop_err  out  1  one-cycle pulse: length < MIN_LEN or > MAX_LEN, body discarded

Behaviour:
- Reset: every output is 0. FSM goes to S_LEN_HI; counters are cleared. `rst` overrides everything, mid-message included, and the partial message is abandoned with no `msg_done`.
- A byte is accepted only in a cycle with `in_valid`=1. There is no backpressure. Idle cycles are legal anywhere and hold state.
- FSM states: S_LEN_HI, S_LEN_LO, S_BODY, S_DROP.
- S_LEN_HI: latch `len[15:8]`, go to S_LEN_LO.
- S_LEN_LO: form the 16-bit length.
  - If length < MIN_LEN or > MAX_LEN: pulse `drop_err` next cycle; `rem` = length; go to S_DROP. If length is 0, return directly to S_LEN_HI.
  - Otherwise: `expected_length` <= length[5:0]; `rem` <= length; pulse `start_flag` next cycle; go to S_BODY.
- `length_valid` pulses exactly one cycle after `start_flag`, so the decoders clear their latch before relatching.
- S_BODY: each accepted byte appears on `payload_out` with `payload_valid_out`=1 one cycle later (latency 1). `rem` decrements by 1 per byte.
  - The first body byte is the type byte. Latch it into `msg_type`. Set `dec_sel` in the same cycle the byte is output; `dec_sel` holds until the next `start_flag`.
  - The first body byte can arrive no earlier than the cycle after LEN_LO, so `start_flag` always leads the first `payload_valid_out` by at least 1 cycle.
  - Length check on the type byte, against the fixed table: 'A'=36, 'X'=23, 'D'=19, 'E'=31. For a known type with mismatched length, pulse `len_err` alongside the type byte output. Forwarding continues unchanged.
  - When `rem` reaches 1 and a byte is accepted: pulse `msg_done` aligned with that byte's `payload_valid_out`, then go to S_LEN_HI.
  - A length-1 message (type byte only) gives `msg_done` on the type byte.
- S_DROP: consume `rem` bytes with no `payload_valid_out`, then go to S_LEN_HI.
- Back-to-back messages: the next S_LEN_HI byte may arrive the cycle after the last body byte. There is no bubble requirement.
- Counters `rem` and `len` are 16-bit with no wrap: `rem` never decrements below 0.

Optional Feature:
- Macro `ITCH_SEQ_STATS_EN`.
- Defined: adds outputs `stat_msgs[31:0]` (increments on `msg_done`), `stat_drops[15:0]` (on `drop_err`) and `stat_len_errs[15:0]` (on `len_err`). All three saturate at max, reset to 0 and update one cycle after the event.
- Undefined: these ports and their registers do not exist. All other behaviour is identical.

Test Plan:
- Stream 00 24 'A' + 35 bytes, continuous valid -> `start_flag` at T, `length_valid` at T+1, first payload at T+1 or later, `dec_sel`=0001, `msg_done` on the 36th payload, no errors.
- 00 13 'D' + 18 bytes with random `in_valid` gaps -> 19 payload bytes in order, `dec_sel`=0100, single `msg_done`, `expected_length`=19.
- 00 14 'D' + 19 bytes -> `len_err` pulse on the type-byte output cycle, 20 bytes forwarded, `msg_done` on the 20th.
- 00 50 + 80 bytes, then 00 17 'X' + 22 bytes -> `drop_err` once, zero payload for the first message, second decoded with `dec_sel`=0010.
- `rst` asserted at body byte 10 of an 'A' message, then a fresh 'E' message -> all outputs 0 after the reset cycle, no `msg_done` for 'A', 'E' decoded normally with `dec_sel`=1000.
- With `ITCH_SEQ_STATS_EN`: 3 good messages, 1 dropped, 1 len-mismatch -> `stat_msgs`=4, `stat_drops`=1, `stat_len_errs`=1.
